lcd_char_responder: RTL and testbench



---
 rtl/lcd_char_responder_pkg.sv | 41 ++++
 rtl/lcd_char_responder_if.sv | 12 +
 rtl/lcd_char_responder_bus_sync.sv | 57 +++++
 rtl/lcd_char_responder.sv | 168 ++++++++++++++++
 tb/tb_lcd_char_responder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_char_responder_pkg.sv
// Shared types and constants for the HD44780-style character-LCD responder.
//   lcd_state_e   : responder FSM states
//   CMD_*         : instruction prefix masks (the highest set bit selects the command)
//   LINE*         : DDRAM line bounds (line 0 = 0x00..0x27, line 1 = 0x40..0x67)
//   SPACE_CHAR    : fill value written by Clear
//   ac_step()     : address-counter advance with line wrap
package lcd_hd44780_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} lcd_state_e;

  typedef logic [6:0] ddram_addr_t;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
  localparam logic [7:0] CMD_FUNC_SET  = 8'h20;
  localparam logic [7:0] CMD_SHIFT     = 8'h10;
  localparam logic [7:0] CMD_DISP_CTRL = 8'h08;
  localparam logic [7:0] CMD_ENTRY     = 8'h04;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;

  localparam ddram_addr_t LINE0_LAST  = 7'h27;
  localparam ddram_addr_t LINE1_FIRST = 7'h40;
  localparam ddram_addr_t LINE1_LAST  = 7'h67;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  // Addresses in the holes between lines snap to the start of the following
  // line regardless of direction; valid addresses wrap line 0 <-> line 1.
  function automatic ddram_addr_t ac_step(input ddram_addr_t a, input logic inc);
    ddram_addr_t r;
    if (a > LINE0_LAST && a < LINE1_FIRST)      r = LINE1_FIRST;
    else if (a > LINE1_LAST)                    r = '0;
    else if (inc)
      r = (a == LINE0_LAST) ? LINE1_FIRST : (a == LINE1_LAST) ? '0 : a + 7'd1;
    else
      r = (a == '0) ? LINE1_LAST : (a == LINE1_FIRST) ? LINE0_LAST : a - 7'd1;
    return r;
  endfunction

endpackage

// File: rtl/lcd_char_responder_if.sv
// Frame-buffer mirror read bus.
//   fb_addr  : DDRAM address to mirror (HD44780 encoding)
//   fb_rdata : data at fb_addr, one clock later
interface lcd_char_responder_if;
  import lcd_hd44780_pkg::*;

  ddram_addr_t fb_addr;
  logic [7:0]  fb_rdata;

  modport master (output fb_addr, input fb_rdata);
  modport slave  (input fb_addr, output fb_rdata);
endinterface

// File: rtl/lcd_char_responder_bus_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus plus E edge detection.
//   lcd_e/lcd_rs/lcd_rw/lcd_data : raw bus inputs
//   e_sync          : synchronized E
//   e_rise/e_fall   : one-cycle edge strobes on e_sync
//   rs/rw/wdata     : bus qualifiers and data captured at e_rise
module lcd_bus_sync
  import lcd_hd44780_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       e_sync,
  output logic       e_rise,
  output logic       e_fall,
  output logic       rs,
  output logic       rw,
  output logic [7:0] wdata
);

  logic [1:0] e_ff, rs_ff, rw_ff;
  logic [7:0] d_ff0, d_ff1;
  logic       e_prev;

  assign e_sync = e_ff[1];
  assign e_rise = e_ff[1] & ~e_prev;
  assign e_fall = ~e_ff[1] & e_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_ff   <= '0;
      rs_ff  <= '0;
      rw_ff  <= '0;
      d_ff0  <= '0;
      d_ff1  <= '0;
      e_prev <= 1'b0;
      rs     <= 1'b0;
      rw     <= 1'b0;
      wdata  <= '0;
    end else begin
      e_ff   <= {e_ff[0], lcd_e};
      rs_ff  <= {rs_ff[0], lcd_rs};
      rw_ff  <= {rw_ff[0], lcd_rw};
      d_ff0  <= lcd_data;
      d_ff1  <= d_ff0;
      e_prev <= e_ff[1];
      if (e_rise) begin
        rs    <= rs_ff[1];
        rw    <= rw_ff[1];
        wdata <= d_ff1;
      end
    end
  end

endmodule

// File: rtl/lcd_char_responder.sv
// Display-side responder for an 8-bit HD44780-style character-LCD bus.
// Captures E-strobed instructions/data into a 128x8 DDRAM image, answers
// busy/address and data reads, and offers an independent mirror read port.
//   clk, reset  : clock, synchronous active-high reset
//   LCD_E/RS/RW : bus strobe and qualifiers (asynchronous)
//   LCD_data    : bidirectional bus, driven only during a read cycle
//   fb          : mirror read port (fb_addr in, fb_rdata out, 1-cycle latency)
//   busy        : busy flag
//   ac          : address counter
//   disp_ctrl   : {display_on, cursor_on, blink_on}
//   cmd_dropped : pulse when a write arrives while busy and is discarded
module lcd_char_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 76000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        LCD_E,
  input  logic                        LCD_RS,
  input  logic                        LCD_RW,
  inout  wire  [7:0]                  LCD_data,
  lcd_char_responder_if.slave         fb,
  output logic                        busy,
  output ddram_addr_t                 ac,
  output logic [2:0]                  disp_ctrl,
  output logic                        cmd_dropped
);

  localparam int unsigned CW = $clog2(CLEAR_CYCLES);
  localparam logic [CW-1:0] EXEC_LOAD  = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);

  logic        e_sync, e_rise, e_fall, rs, rw;
  logic [7:0]  wdata;

  lcd_bus_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .lcd_e    (LCD_E),
    .lcd_rs   (LCD_RS),
    .lcd_rw   (LCD_RW),
    .lcd_data (LCD_data),
    .e_sync   (e_sync),
    .e_rise   (e_rise),
    .e_fall   (e_fall),
    .rs       (rs),
    .rw       (rw),
    .wdata    (wdata)
  );

  lcd_state_e  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  ddram_addr_t ac_nxt;
  logic        id, id_nxt;
  logic [2:0]  disp_nxt;
  logic        drop_nxt;
  logic        mem_we;
  ddram_addr_t mem_waddr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem [0:127];
  logic [7:0]  rd_reg;
  logic        rise_d;

  assign busy = (state != ST_IDLE);

  // The bus is held off during the rise cycle (rw may still hold the previous
  // cycle's value) and the following cycle (rd_reg not yet reloaded).
  assign LCD_data = (e_sync && rw && !e_rise && !rise_d) ? rd_reg : 8'bz;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ac_nxt    = ac;
    id_nxt    = id;
    disp_nxt  = disp_ctrl;
    drop_nxt  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ac;
    mem_wdata = wdata;

    case (state)
      ST_EXEC: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      ST_CLEAR: begin
        // The first 128 counts double as the fill address.
        if ((cnt >> 7) == '0) begin
          mem_we    = 1'b1;
          mem_waddr = cnt[6:0];
          mem_wdata = SPACE_CHAR;
        end
        if (cnt == CLEAR_LAST) state_nxt = ST_IDLE;
        else                   cnt_nxt   = cnt + CW'(1);
      end
      default: ;
    endcase

    if (e_fall && !reset) begin
      if (rw) begin
        if (rs) begin
          ac_nxt = ac_step(ac, id);
          if (state != ST_CLEAR) begin
            state_nxt = ST_EXEC;
            cnt_nxt   = EXEC_LOAD;
          end
        end
      end else if (busy) begin
        drop_nxt = 1'b1;
      end else begin
        state_nxt = ST_EXEC;
        cnt_nxt   = EXEC_LOAD;
        if (rs) begin
          mem_we = 1'b1;
          ac_nxt = ac_step(ac, id);
        end else if ((wdata & CMD_SET_DDRAM) != '0) begin
          ac_nxt = wdata[6:0];
        end else if ((wdata & (CMD_SET_CGRAM | CMD_FUNC_SET)) != '0) begin
          // accepted without visible effect
        end else if ((wdata & CMD_SHIFT) != '0) begin
          if (!wdata[3]) ac_nxt = ac_step(ac, wdata[2]);
        end else if ((wdata & CMD_DISP_CTRL) != '0) begin
          disp_nxt = wdata[2:0];
        end else if ((wdata & CMD_ENTRY) != '0) begin
          id_nxt = wdata[1];
        end else if ((wdata & CMD_HOME) != '0) begin
          ac_nxt = '0;
        end else if ((wdata & CMD_CLEAR) != '0) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
          ac_nxt    = '0;
          id_nxt    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_CLEAR;
      cnt         <= '0;
      ac          <= '0;
      id          <= 1'b1;
      disp_ctrl   <= '0;
      cmd_dropped <= 1'b0;
      rise_d      <= 1'b0;
      rd_reg      <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ac          <= ac_nxt;
      id          <= id_nxt;
      disp_ctrl   <= disp_nxt;
      cmd_dropped <= drop_nxt;
      rise_d      <= e_rise;
      if (rise_d && rw)
        rd_reg <= rs ? mem[ac] : {busy, ac};
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
    fb.fb_rdata <= mem[fb.fb_addr];
  end

endmodule

// File: tb/tb_lcd_char_responder.sv
module tb_lcd_char_responder;
  localparam int unsigned BUSY_CYC  = 60;
  localparam int unsigned CLEAR_CYC = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tb_e = 1'b0, tb_rs = 1'b0, tb_rw = 1'b0, tb_oe = 1'b0;
  logic [7:0] tb_dout = '0;
  wire  [7:0] lcd_data;
  logic       busy, cmd_dropped;
  logic [6:0] ac;
  logic [2:0] disp_ctrl;

  int n_cmp = 0, n_bad = 0, drop_seen = 0;

  logic [7:0] m_mem [0:127];
  logic [6:0] m_ac;
  logic       m_id;
  logic [2:0] m_disp;

  assign lcd_data = tb_oe ? tb_dout : 8'bz;

  lcd_char_responder_if fb_if ();

  lcd_char_responder #(.BUSY_CYCLES(BUSY_CYC), .CLEAR_CYCLES(CLEAR_CYC)) dut (
    .clk         (clk),
    .reset       (reset),
    .LCD_E       (tb_e),
    .LCD_RS      (tb_rs),
    .LCD_RW      (tb_rw),
    .LCD_data    (lcd_data),
    .fb          (fb_if.slave),
    .busy        (busy),
    .ac          (ac),
    .disp_ctrl   (disp_ctrl),
    .cmd_dropped (cmd_dropped)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_dropped) drop_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Display addresses as a linear 80-cell ring: cells 0..39 on line 0, 40..79 on line 1.
  function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
    int pos;
    if (a >= 7'h28 && a <= 7'h3F) return 7'h40;
    if (a >= 7'h68) return 7'h00;
    pos = (a >= 7'h40) ? 40 + int'(a) - 64 : int'(a);
    pos = inc ? (pos + 1) % 80 : (pos + 79) % 80;
    return (pos < 40) ? 7'(pos) : 7'(pos - 40 + 64);
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 128; a++) m_mem[a] = 8'h20;
    m_ac = '0;
    m_id = 1'b1;
  endtask

  task automatic model_cmd(input logic rs, input logic [7:0] d);
    if (rs) begin
      m_mem[m_ac] = d;
      m_ac = m_step(m_ac, m_id);
    end else if (d[7])      m_ac = d[6:0];
    else if (d[6] || d[5])  m_ac = m_ac;
    else if (d[4])          begin if (!d[3]) m_ac = m_step(m_ac, d[2]); end
    else if (d[3])          m_disp = d[2:0];
    else if (d[2])          m_id = d[1];
    else if (d[1])          m_ac = '0;
    else if (d[0])          model_clear();
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    tb_rs = rs; tb_rw = 1'b0; tb_dout = d; tb_oe = 1'b1;
    @(negedge clk);
    tb_e = 1'b1;
    repeat (5) @(negedge clk);
    tb_e = 1'b0;
    repeat (2) @(negedge clk);
    tb_oe = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] d);
    @(negedge clk);
    tb_oe = 1'b0; tb_rs = rs; tb_rw = 1'b1;
    @(negedge clk);
    tb_e = 1'b1;
    repeat (5) @(negedge clk);
    d = lcd_data;
    tb_e = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic check_fb(input logic [6:0] a);
    fb_if.fb_addr = a;
    @(negedge clk);
    check($sformatf("fb[%0h]", a), fb_if.fb_rdata, m_mem[a]);
  endtask

  task automatic check_fb_all();
    for (int a = 0; a < 128; a++) check_fb(7'(a));
  endtask

  task automatic reset_and_check();
    int n = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_in_reset", busy, 1);
    check("disp_in_reset", disp_ctrl, 0);
    check("drop_in_reset", cmd_dropped, 0);
    reset = 1'b0;
    while (busy && n < CLEAR_CYC + 100) begin
      n++;
      @(negedge clk);
    end
    check("clear_len", n, CLEAR_CYC);
    model_clear();
    m_disp = '0;
    check("ac_after_clear", ac, m_ac);
    check_fb_all();
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    bus_write(rs, d);
    model_cmd(rs, d);
    wait_idle();
  endtask

  initial begin
    logic [7:0] r;
    int unsigned op;
    logic [7:0] d;

    fb_if.fb_addr = '0;
    m_disp = '0;
    repeat (2) @(negedge clk);
    reset_and_check();

    // line-0 end wraps to line 1 start
    wr(0, 8'hA7); wr(1, 8'h41); wr(1, 8'h42);
    check_fb(7'h27); check_fb(7'h40);
    check("ac_wrap_fwd", ac, 7'h41);

    // decrement from 0 wraps to line-1 end
    wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h5A);
    check_fb(7'h00);
    check("ac_wrap_back", ac, 7'h67);
    wr(0, 8'h06);

    // write while busy is discarded; status read answers while busy
    bus_write(1, 8'h31);
    model_cmd(1, 8'h31);
    bus_write(1, 8'h77);
    bus_read(0, r);
    check("status_busy", r, {1'b1, m_ac});
    wait_idle();
    check("drop_count", drop_seen, 1);
    check_fb(m_ac);
    check_fb(7'h67);

    // display control, then data read and bus release
    wr(0, 8'h0E);
    check("disp_ctrl", disp_ctrl, 3'b110);
    wr(0, 8'h85); wr(1, 8'h33); wr(0, 8'h85);
    bus_read(1, r);
    check("data_read", r, 8'h33);
    m_ac = m_step(m_ac, m_id);
    tb_dout = 8'hC3; tb_oe = 1'b1;
    #1;
    check("bus_released", lcd_data, 8'hC3);
    tb_oe = 1'b0;
    wait_idle();
    check("ac_after_read", ac, 7'h06);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 20);
      d  = 8'($urandom);
      case (op)
        0, 1, 2, 3, 4: wr(1, d);
        5, 6:    wr(0, {1'b1, d[6:0]});
        7:       wr(0, {6'b000001, d[1:0]});
        8, 9:    wr(0, {4'b0001, d[3:0]});
        10:      wr(0, {5'b00001, d[2:0]});
        11:      wr(0, d[0] ? {2'b01, d[5:0]} : {3'b001, d[4:0]});
        12:      wr(0, 8'h02);
        13:      wr(0, 8'h01);
        14, 15, 16: begin
          bus_read(1, r);
          check("rnd_rdata", r, m_mem[m_ac]);
          m_ac = m_step(m_ac, m_id);
          wait_idle();
        end
        default: begin
          bus_read(0, r);
          check("rnd_status", r, {1'b0, m_ac});
        end
      endcase
      check("rnd_ac", ac, m_ac);
      check("rnd_disp", disp_ctrl, m_disp);
    end
    check_fb_all();
    check("drop_total", drop_seen, 1);

    // reset in the middle of an EXEC period
    bus_write(0, 8'h0C);
    check("disp_before_reset", disp_ctrl, 3'b100);
    check("busy_before_reset", busy, 1);
    reset_and_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
